mac_share_arb: RTL

//  Shares one pipelined multiply-accumulate unit (o = a*b + ci, fixed LAT-cycle latency,
//  no enable and no stall) between NREQ requesters.
//  - Grants one requester per cycle, round-robin.
//  - Drives the MAC operand bus.
//  - Carries a requester tag down a shadow pipeline matched to the MAC latency.
//  - Steers each result back to its owner with a one-cycle valid pulse.

---
 rtl/mac_share_arb.sv | 108 ++++++++++
 1 files changed

// File: rtl/mac_share_arb.sv
// rtl/mac_share_arb.sv - round-robin sharing of one pipelined MAC between NREQ requesters
module mac_share_arb #(
  parameter int BITS = 8,
  parameter int NREQ = 4,
  parameter int LAT  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*BITS-1:0]   req_a,
  input  logic [NREQ*BITS-1:0]   req_b,
  input  logic [NREQ*2*BITS-1:0] req_ci,
  output logic [BITS-1:0]        mac_a,
  output logic [BITS-1:0]        mac_b,
  output logic [2*BITS-1:0]      mac_ci,
  input  logic [2*BITS-1:0]      mac_o,
  output logic [NREQ-1:0]        resp_valid,
  output logic [2*BITS-1:0]      resp_o,
  output logic                   idle
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;
  logic           found;
  logic           hs;
  int             scan;

  logic [LAT-1:0] tag_v;
  logic [IDW-1:0] tag_id [LAT];

  // Round-robin scan starting at rr_ptr; reset and hold mask every candidate
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = 0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NREQ) scan = scan - NREQ;
      idx = IDW'(scan);
      if (!found && req_valid[idx] && !hold && !rst) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // One-hot grant; the winner is by construction valid, so a grant is a handshake
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = found && (winner == IDW'(i));
    end
    hs = |(req_valid & req_ready);
  end

  // Operand mux; zeros when idle keep the MAC inputs quiet
  always_comb begin
    mac_a  = '0;
    mac_b  = '0;
    mac_ci = '0;
    if (hs) begin
      mac_a  = req_a[winner*BITS +: BITS];
      mac_b  = req_b[winner*BITS +: BITS];
      mac_ci = req_ci[winner*2*BITS +: 2*BITS];
    end
  end

  // Pointer advances past the winner only when an operation is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (hs) begin
      rr_ptr <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
    end
  end

  // Tag shadow pipe, LAT deep so the last stage lines up with mac_o
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_v[0]  <= hs;
      tag_id[0] <= winner;
      for (int k = 1; k < LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  // Steer the returning result to its owner and report pipe occupancy
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid[i] = tag_v[LAT-1] && (tag_id[LAT-1] == IDW'(i));
    end
    resp_o = mac_o;
    idle   = ~|tag_v;
  end

endmodule
